// File: rtl/row_loader_if.sv
// Word stream from the host or UART bridge into the row loader.
// The host drives data/valid; the loader answers with ready.
interface row_loader_if #(
    parameter int IW = 16
);
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/row_loader.sv
// Row configuration loader: decodes header words, fills per-core program
// storage and lengths, and holds the row until a RUN command arrives.
module row_loader #(
    parameter int NCORES = 4,
    parameter int MAXLEN = 15,
    parameter int IW     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    row_loader_if.slave                         host,
    output logic [NCORES*MAXLEN-1:0][IW-1:0]    prog,
    output logic [NCORES-1:0][3:0]              plen,
    output logic                                core_hold,
    output logic                                busy,
    output logic                                err
);

    typedef enum logic [0:0] {HDR = 1'b0, DATA = 1'b1} state_t;

    localparam logic [4:0] NCORES_W = 5'(NCORES);
    localparam logic [3:0] MAXLEN_W = 4'(MAXLEN);

    state_t     state_r, state_s;
    logic       ready_r;
    logic [3:0] idx_r, idx_s;
    logic [3:0] len_r, len_s;
    logic [3:0] cnt_r, cnt_s;
    logic       hold_s, busy_s, err_s;
    logic       wr_en_s, commit_s, clr_one_s, clr_all_s;

    logic       accept_s;
    logic [1:0] op_s;
    logic [3:0] hidx_s, hlen_s;
    logic       load_ok_s;

    assign host.in_ready = ready_r;
    assign accept_s      = host.in_valid & ready_r;
    assign op_s          = host.in_data[15:14];
    assign hidx_s        = host.in_data[11:8];
    assign hlen_s        = host.in_data[3:0];
    assign load_ok_s     = ({1'b0, hidx_s} < NCORES_W) && (hlen_s <= MAXLEN_W);

    // Next-state and command decode for the header/data sequencer
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        len_s     = len_r;
        cnt_s     = cnt_r;
        hold_s    = core_hold;
        busy_s    = busy;
        err_s     = err;
        wr_en_s   = 1'b0;
        commit_s  = 1'b0;
        clr_one_s = 1'b0;
        clr_all_s = 1'b0;
        if (accept_s) begin
            case (state_r)
                HDR: begin
                    case (op_s)
                        2'b01: begin
                            if (load_ok_s) begin
                                hold_s    = 1'b1;
                                clr_one_s = 1'b1;
                                idx_s     = hidx_s;
                                len_s     = hlen_s;
                                cnt_s     = 4'd0;
                                if (hlen_s != 4'd0) begin
                                    state_s = DATA;
                                    busy_s  = 1'b1;
                                end else begin
                                    state_s = HDR;
                                    busy_s  = 1'b0;
                                end
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                        2'b10: hold_s = 1'b0;
                        2'b11: begin
                            hold_s    = 1'b1;
                            clr_all_s = 1'b1;
                        end
                        default: hold_s = core_hold;
                    endcase
                end
                DATA: begin
                    wr_en_s = 1'b1;
                    // Length is committed together with the final word
                    if (cnt_r == len_r - 4'd1) begin
                        commit_s = 1'b1;
                        state_s  = HDR;
                        busy_s   = 1'b0;
                        cnt_s    = 4'd0;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end
                default: state_s = HDR;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Sequencer and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= HDR;
            ready_r   <= 1'b0;
            idx_r     <= 4'd0;
            len_r     <= 4'd0;
            cnt_r     <= 4'd0;
            core_hold <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_s;
            ready_r   <= 1'b1;
            idx_r     <= idx_s;
            len_r     <= len_s;
            cnt_r     <= cnt_s;
            core_hold <= hold_s;
            busy      <= busy_s;
            err       <= err_s;
        end
    end

    // Program storage and committed lengths
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prog <= '0;
            plen <= '0;
        end else begin
            for (int c = 0; c < NCORES; c++) begin
                if (clr_all_s) begin
                    plen[c] <= 4'd0;
                end else if (clr_one_s && (hidx_s == 4'(c))) begin
                    plen[c] <= 4'd0;
                end else if (commit_s && (idx_r == 4'(c))) begin
                    plen[c] <= len_r;
                end
                for (int i = 0; i < MAXLEN; i++) begin
                    if (wr_en_s && (idx_r == 4'(c)) && (cnt_r == 4'(i))) begin
                        prog[c*MAXLEN+i] <= host.in_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_row_loader.sv
// Randomized bench for row_loader against a word-level reference model,
// with directed scenarios pinned by hand-computed values.
module tb_row_loader;

    localparam int NC = 4;
    localparam int ML = 15;

    logic clk = 1'b0;
    logic rst;
    logic [NC*ML-1:0][15:0] prog;
    logic [NC-1:0][3:0]     plen;
    logic core_hold, busy, err;

    row_loader_if #(.IW(16)) bus ();

    row_loader #(.NCORES(NC), .MAXLEN(ML), .IW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (bus.slave),
        .prog      (prog),
        .plen      (plen),
        .core_hold (core_hold),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: a load is "words remaining" into one core's slots
    logic [NC*ML-1:0][15:0] m_prog;
    logic [NC-1:0][3:0]     m_plen;
    logic m_hold, m_busy, m_err, m_ready;
    int   m_left, m_core, m_pos, m_len;

    function automatic int f_op(logic [15:0] d);   return int'(d[15:14]); endfunction
    function automatic int f_core(logic [15:0] d); return int'(d[11:8]);  endfunction
    function automatic int f_len(logic [15:0] d);  return int'(d[3:0]);   endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_prog  <= '0;
            m_plen  <= '0;
            m_hold  <= 1'b1;
            m_busy  <= 1'b0;
            m_err   <= 1'b0;
            m_ready <= 1'b0;
            m_left  <= 0;
            m_core  <= 0;
            m_pos   <= 0;
            m_len   <= 0;
        end else begin
            m_ready <= 1'b1;
            if (bus.in_valid && m_ready) begin
                if (m_left > 0) begin
                    m_prog[m_core*ML+m_pos] <= bus.in_data;
                    m_pos  <= m_pos + 1;
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_plen[m_core] <= 4'(m_len);
                        m_busy <= 1'b0;
                    end
                end else if (f_op(bus.in_data) == 1) begin
                    if (f_core(bus.in_data) < NC && f_len(bus.in_data) <= ML) begin
                        m_hold <= 1'b1;
                        m_plen[f_core(bus.in_data)] <= 4'd0;
                        m_core <= f_core(bus.in_data);
                        m_len  <= f_len(bus.in_data);
                        m_left <= f_len(bus.in_data);
                        m_pos  <= 0;
                        m_busy <= (f_len(bus.in_data) > 0);
                    end else begin
                        m_err <= 1'b1;
                    end
                end else if (f_op(bus.in_data) == 2) begin
                    m_hold <= 1'b0;
                end else if (f_op(bus.in_data) == 3) begin
                    m_hold <= 1'b1;
                    m_plen <= '0;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int bad;
        cmp("in_ready", 32'(bus.in_ready), 32'(m_ready));
        cmp("core_hold", 32'(core_hold), 32'(m_hold));
        cmp("busy", 32'(busy), 32'(m_busy));
        cmp("err", 32'(err), 32'(m_err));
        cmp("plen", 32'(plen), 32'(m_plen));
        bad = -1;
        for (int k = NC*ML-1; k >= 0; k--) begin
            if (prog[k] !== m_prog[k]) bad = k;
        end
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL prog[%0d]: got %0h expected %0h at %0t", bad, prog[bad], m_prog[bad], $time);
        end
    endtask

    // One accepted-or-idle cycle, then compare on the falling edge
    task automatic send(input logic v, input logic [15:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int n);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        rst = 1'b1;
        #1;
        cmp("ready_low_at_release", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_all();
        cmp("ready_after_release", 32'(bus.in_ready), 32'd1);
    endtask

    logic [15:0] rd;

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        @(negedge clk);
        do_reset(2);
        cmp("rst_hold", 32'(core_hold), 32'd1);
        cmp("rst_plen", 32'(plen), 32'd0);
        cmp("rst_prog0", 32'(prog[0]), 32'd0);

        // Single load of core 1 then run
        send(1'b1, 16'h4103);
        cmp("l1_busy", 32'(busy), 32'd1);
        send(1'b1, 16'h1111);
        send(1'b1, 16'h2222);
        cmp("l1_plen_partial", 32'(plen[1]), 32'd0);
        send(1'b1, 16'h3333);
        cmp("l1_plen", 32'(plen[1]), 32'd3);
        cmp("l1_p15", 32'(prog[15]), 32'h1111);
        cmp("l1_p16", 32'(prog[16]), 32'h2222);
        cmp("l1_p17", 32'(prog[17]), 32'h3333);
        send(1'b1, 16'h8000);
        cmp("run_hold", 32'(core_hold), 32'd0);

        // Reload core 0 while running, with idle gaps
        send(1'b1, 16'h4002);
        cmp("rl_hold", 32'(core_hold), 32'd1);
        send(1'b1, 16'hAAAA);
        send(1'b0, 16'h8000);
        cmp("rl_plen_gap", 32'(plen[0]), 32'd0);
        send(1'b1, 16'hBBBB);
        cmp("rl_plen", 32'(plen[0]), 32'd2);
        cmp("rl_p1", 32'(prog[1]), 32'hBBBB);
        send(1'b0, 16'h0000);
        cmp("rl_hold_stays", 32'(core_hold), 32'd1);

        // Bad index, then zero-length load
        send(1'b1, 16'h4501);
        cmp("bad_err", 32'(err), 32'd1);
        cmp("bad_busy", 32'(busy), 32'd0);
        send(1'b1, 16'h4200);
        cmp("z_plen2", 32'(plen[2]), 32'd0);
        cmp("z_busy", 32'(busy), 32'd0);

        // Header-looking data words
        send(1'b1, 16'h8000);
        send(1'b1, 16'h4302);
        send(1'b1, 16'h8000);
        cmp("hd_hold", 32'(core_hold), 32'd1);
        send(1'b1, 16'h0001);
        cmp("hd_p45", 32'(prog[45]), 32'h8000);
        cmp("hd_plen3", 32'(plen[3]), 32'd2);
        send(1'b1, 16'hC000);
        cmp("clr_plen", 32'(plen), 32'd0);
        cmp("clr_p45", 32'(prog[45]), 32'h8000);

        // Reset in the middle of a load
        send(1'b1, 16'h4103);
        send(1'b1, 16'h5555);
        do_reset(2);
        cmp("mr_p15", 32'(prog[15]), 32'd0);
        cmp("mr_busy", 32'(busy), 32'd0);
        cmp("mr_err", 32'(err), 32'd0);
        send(1'b1, 16'h4001);
        send(1'b1, 16'hABCD);
        cmp("mr_new_p0", 32'(prog[0]), 32'hABCD);
        cmp("mr_new_plen0", 32'(plen[0]), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1 + $urandom_range(0, 2));
            end else begin
                rd = 16'($urandom);
                if ($urandom_range(0, 2) != 0) begin
                    rd[11:8] = 4'($urandom_range(0, 5));
                    if ($urandom_range(0, 3) == 0) rd[3:0] = 4'd0;
                end
                send($urandom_range(0, 3) != 0, rd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
